// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN queue write-side arbiter and its helpers.
// Holds the FSM encoding and the default data width.
package kpn_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int DEFAULT_BITS_NUMBER = 16;

endpackage

// File: rtl/kpn_queue_arbiter_if.sv
// Producer lanes plus queue write port of the KPN queue arbiter.
// The master modport is the arbiter; the slave modport is its environment.
interface kpn_queue_arbiter_if
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER = DEFAULT_BITS_NUMBER,
  parameter int NUM_REQ     = 4
);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*BITS_NUMBER-1:0] data_in;
  logic                           fifo_full;
  logic [NUM_REQ-1:0]             ack;
  logic [NUM_REQ-1:0]             grant;
  logic                           fifo_wr;
  logic [BITS_NUMBER-1:0]         fifo_wdata;

  modport master (
    input  req, data_in, fifo_full,
    output ack, grant, fifo_wr, fifo_wdata
  );

  modport slave (
    output req, data_in, fifo_full,
    input  ack, grant, fifo_wr, fifo_wdata
  );

endinterface

// File: rtl/kpn_rr_pick.sv
// Combinational round-robin picker: first set request strictly after
// last_winner, wrapping from NUM_REQ-1 back to 0.
module kpn_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_winner,
  output logic               any,
  output logic [IW-1:0]      winner
);

  logic        found;
  int unsigned idx;

  // NOTE: every output and temporary gets a default before the loop so no
  // path leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    any    = |req;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    // i = NUM_REQ revisits last_winner itself, so a sole requester re-wins.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_winner) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kpn_queue_arbiter.sv
// Round-robin write arbiter: NUM_REQ KPN producers share one queue write port,
// each grant bounded to MAX_BURST words, stalling while the queue is full.
module kpn_queue_arbiter
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER = DEFAULT_BITS_NUMBER,
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  kpn_queue_arbiter_if.master  bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [CW-1:0] LAST_BEAT   = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] RESET_LAST  = IW'(NUM_REQ - 1);

  state_t               state, state_nx;
  logic [IW-1:0]        grant_idx, grant_idx_nx;
  logic [IW-1:0]        last_winner, last_winner_nx;
  logic [CW-1:0]        burst_cnt, burst_cnt_nx;
  logic [NUM_REQ-1:0]   grant_q, grant_nx;

  logic                 pick_any;
  logic [IW-1:0]        pick_idx;
  logic                 granted_req;
  logic                 write;
  logic [BITS_NUMBER-1:0] lane;

  kpn_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req         (bus.req),
    .last_winner (last_winner),
    .any         (pick_any),
    .winner      (pick_idx)
  );

  assign lane        = bus.data_in[grant_idx*BITS_NUMBER +: BITS_NUMBER];
  assign granted_req = bus.req[grant_idx];
  assign write       = (state == GRANT) && granted_req && !bus.fifo_full;

  // Queue-side outputs stay combinational so a word is written in the same
  // cycle the producer presents it; only the grant itself is registered.
  assign bus.fifo_wr    = write;
  assign bus.ack        = write ? (NUM_REQ'(1) << grant_idx) : '0;
  assign bus.fifo_wdata = (state == GRANT) ? lane : '0;
  assign bus.grant      = grant_q;

  always_comb begin
    state_nx       = state;
    grant_idx_nx   = grant_idx;
    last_winner_nx = last_winner;
    burst_cnt_nx   = burst_cnt;
    grant_nx       = grant_q;

    unique case (state)
      IDLE: begin
        if (pick_any) begin
          state_nx       = GRANT;
          grant_idx_nx   = pick_idx;
          last_winner_nx = pick_idx;
          burst_cnt_nx   = '0;
          grant_nx       = NUM_REQ'(1) << pick_idx;
        end
      end
      GRANT: begin
        if (!granted_req) begin
          // A dropped request releases even if the queue is full this cycle.
          state_nx     = IDLE;
          grant_nx     = '0;
          burst_cnt_nx = '0;
        end else if (!bus.fifo_full) begin
          if (burst_cnt == LAST_BEAT) begin
            state_nx     = IDLE;
            grant_nx     = '0;
            burst_cnt_nx = '0;
          end else begin
            burst_cnt_nx = burst_cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant_idx   <= '0;
      last_winner <= RESET_LAST;
      burst_cnt   <= '0;
      grant_q     <= '0;
    end else begin
      state       <= state_nx;
      grant_idx   <= grant_idx_nx;
      last_winner <= last_winner_nx;
      burst_cnt   <= burst_cnt_nx;
      grant_q     <= grant_nx;
    end
  end

  a_grant_onehot0 : assert property (
    @(posedge clk) disable iff (!reset_n) $onehot0(grant_q)
  );

  a_grant_matches_state : assert property (
    @(posedge clk) disable iff (!reset_n) ((state == GRANT) == (grant_q != '0))
  );

  a_burst_bounded : assert property (
    @(posedge clk) disable iff (!reset_n) (burst_cnt <= LAST_BEAT)
  );

endmodule

// File: tb/tb_kpn_queue_arbiter.sv
// Directed bench for kpn_queue_arbiter (4 producers, 16-bit words, bursts of 4).
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_kpn_queue_arbiter;

  localparam int BW = 16;
  localparam int NR = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  kpn_queue_arbiter_if #(.BITS_NUMBER(BW), .NUM_REQ(NR)) bus ();

  kpn_queue_arbiter #(
    .BITS_NUMBER (BW),
    .NUM_REQ     (NR),
    .MAX_BURST   (MB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [BW-1:0] lane_data [NR] = '{16'h1111, 16'h2222, 16'hA5A5, 16'h3333};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [NR-1:0] eg, input logic ew,
                            input logic [NR-1:0] ea, input logic [BW-1:0] ed);
    check({tag, ".grant"}, 32'(bus.grant), 32'(eg));
    check({tag, ".fifo_wr"}, 32'(bus.fifo_wr), 32'(ew));
    check({tag, ".ack"}, 32'(bus.ack), 32'(ea));
    check({tag, ".wdata"}, 32'(bus.fifo_wdata), 32'(ed));
  endtask

  // One clock cycle: check on the falling edge, return just after the next rising edge.
  task automatic cyc(input string tag, input logic [NR-1:0] eg, input logic ew,
                     input logic [NR-1:0] ea, input logic [BW-1:0] ed);
    @(negedge clk);
    check_outs(tag, eg, ew, ea, ed);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input string tag);
    cyc(tag, '0, 1'b0, '0, '0);
  endtask

  task automatic wr_cyc(input string tag, input int lane);
    cyc(tag, NR'(1 << lane), 1'b1, NR'(1 << lane), lane_data[lane]);
  endtask

  task automatic hold_cyc(input string tag, input int lane);
    cyc(tag, NR'(1 << lane), 1'b0, '0, lane_data[lane]);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.req       = '0;
    bus.fifo_full = 1'b0;
    bus.data_in   = {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};

    // Reset: outputs quiet, even with every producer requesting.
    idle_cyc("rst");
    bus.req = 4'b1111;
    idle_cyc("rst_req");
    bus.req = 4'b0000;
    reset_n = 1'b1;

    // No requests: nothing granted or written.
    for (int i = 0; i < 10; i++) idle_cyc("idle");

    // Single producer on lane 2: burst of 4, one bubble, re-grant.
    bus.req = 4'b0100;
    idle_cyc("p2.arb");
    for (int i = 0; i < MB; i++) wr_cyc("p2.wr_a", 2);
    idle_cyc("p2.bubble");
    for (int i = 0; i < MB; i++) wr_cyc("p2.wr_b", 2);
    bus.req = 4'b0000;
    idle_cyc("p2.end");

    // Fresh reset, then all four requesting: 0,1,2,3,0 with bubbles.
    reset_n = 1'b0;
    idle_cyc("p3.rst");
    reset_n = 1'b1;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      idle_cyc("p3.bubble");
      for (int i = 0; i < MB; i++) wr_cyc("p3.wr", k % NR);
    end
    bus.req = 4'b0000;
    idle_cyc("p3.end");

    // Lane 1 stalled by fifo_full for 3 cycles after its second write.
    bus.req = 4'b0010;
    idle_cyc("p4.arb");
    wr_cyc("p4.wr1", 1);
    wr_cyc("p4.wr2", 1);
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) hold_cyc("p4.stall", 1);
    bus.fifo_full = 1'b0;
    wr_cyc("p4.wr3", 1);
    wr_cyc("p4.wr4", 1);
    bus.req = 4'b0000;
    idle_cyc("p4.end");

    // Lane 3 drops after one write; pending lane 0 wins via wrap-around.
    bus.req = 4'b1000;
    idle_cyc("p5.arb");
    wr_cyc("p5.wr3", 3);
    bus.req = 4'b0001;
    hold_cyc("p5.drop", 3);
    idle_cyc("p5.rel");
    wr_cyc("p5.wr0", 0);
    // Request drop coinciding with fifo_full: release, no write.
    bus.req       = 4'b0000;
    bus.fifo_full = 1'b1;
    hold_cyc("p5.dropfull", 0);
    bus.fifo_full = 1'b0;
    idle_cyc("p5.end");

    // Reset in the middle of a lane 2 burst, then lane 0 has priority.
    bus.req = 4'b0100;
    idle_cyc("p6.arb");
    wr_cyc("p6.wr1", 2);
    wr_cyc("p6.wr2", 2);
    reset_n = 1'b0;
    #1;
    check_outs("p6.rst_now", '0, 1'b0, '0, '0);
    idle_cyc("p6.rst");
    reset_n = 1'b1;
    bus.req = 4'b0101;
    idle_cyc("p6.arb2");
    wr_cyc("p6.wr0", 0);
    bus.req = 4'b0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
